// File: rtl/morra_cinese_match.sv
// Two-player rock-paper-scissors match controller with a tournament scoreboard.
// Rounds are judged on MOVE_VALID cycles in PLAY; a game ends on an advantage
// or a round limit, and per-player game-win totals persist across START.
module morra_cinese_match #(
    parameter int ADV_LIMIT  = 2,
    parameter int MIN_ROUNDS = 4,
    parameter int EXTRA_BASE = 4,
    parameter int REPEAT_BAN = 1,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               START,
    input  logic               MOVE_VALID,
    input  logic [1:0]         P1,
    input  logic [1:0]         P2,
    output logic               ROUND_VALID,
    output logic [1:0]         ROUND,
    output logic [1:0]         GAME,
    output logic [5:0]         PLAYED,
    output logic               BUSY,
    output logic [SCORE_W-1:0] SCORE1,
    output logic [SCORE_W-1:0] SCORE2
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_END} state_t;

    state_t              state, state_n;
    logic                rv, rv_n;
    logic [1:0]          round, round_n;
    logic [1:0]          game, game_n;
    logic [5:0]          played, played_n;
    logic signed [6:0]   adv, adv_n;
    logic [6:0]          adv_mag;
    logic [5:0]          maxr, maxr_n;
    logic                first, first_n;
    logic [1:0]          pwin, pwin_n;
    logic [1:0]          pmove, pmove_n;
    logic [SCORE_W-1:0]  score1, score1_n;
    logic [SCORE_W-1:0]  score2, score2_n;

    logic is_void;
    logic p1_wins;
    logic p2_wins;

    // A round is void on an invalid move or when the previous winner repeats its winning move.
    assign is_void = (P1 == 2'b00) || (P2 == 2'b00) ||
                     ((REPEAT_BAN != 0) && (pwin == 2'b01) && (P1 == pmove)) ||
                     ((REPEAT_BAN != 0) && (pwin == 2'b10) && (P2 == pmove));

    assign p1_wins = ((P1 == 2'b01) && (P2 == 2'b11)) ||
                     ((P1 == 2'b10) && (P2 == 2'b01)) ||
                     ((P1 == 2'b11) && (P2 == 2'b10));

    assign p2_wins = ((P2 == 2'b01) && (P1 == 2'b11)) ||
                     ((P2 == 2'b10) && (P1 == 2'b01)) ||
                     ((P2 == 2'b11) && (P1 == 2'b10));

    // Next-state logic: START restarts the game, otherwise judge an accepted move and test for game end.
    always_comb begin
        state_n  = state;
        rv_n     = 1'b0;
        round_n  = 2'b00;
        game_n   = game;
        played_n = played;
        adv_n    = adv;
        adv_mag  = 7'd0;
        maxr_n   = maxr;
        first_n  = first;
        pwin_n   = pwin;
        pmove_n  = pmove;
        score1_n = score1;
        score2_n = score2;

        if (START) begin
            state_n  = S_PLAY;
            played_n = 6'd0;
            adv_n    = 7'sd0;
            game_n   = 2'b00;
            pwin_n   = 2'b00;
            pmove_n  = 2'b00;
            first_n  = 1'b1;
        end else if ((state == S_PLAY) && MOVE_VALID) begin
            rv_n = 1'b1;
            if (first) begin
                maxr_n  = 6'({P1, P2}) + 6'(EXTRA_BASE);
                first_n = 1'b0;
            end
            if (is_void) begin
                round_n = 2'b00;
            end else if (p1_wins) begin
                round_n  = 2'b01;
                adv_n    = adv + 7'sd1;
                played_n = played + 6'd1;
                pwin_n   = 2'b01;
                pmove_n  = P1;
            end else if (p2_wins) begin
                round_n  = 2'b10;
                adv_n    = adv - 7'sd1;
                played_n = played + 6'd1;
                pwin_n   = 2'b10;
                pmove_n  = P2;
            end else begin
                round_n  = 2'b11;
                played_n = played + 6'd1;
                pwin_n   = 2'b00;
                pmove_n  = 2'b00;
            end
            adv_mag = adv_n[6] ? (7'd0 - adv_n) : adv_n;
            if ((played_n >= 6'(MIN_ROUNDS)) &&
                ((adv_mag >= 7'(ADV_LIMIT)) || (played_n >= maxr_n))) begin
                state_n = S_END;
                if (adv_n > 7'sd0) begin
                    game_n = 2'b01;
                    if (score1 != {SCORE_W{1'b1}}) score1_n = score1 + 1'b1;
                end else if (adv_n < 7'sd0) begin
                    game_n = 2'b10;
                    if (score2 != {SCORE_W{1'b1}}) score2_n = score2 + 1'b1;
                end else begin
                    game_n = 2'b11;
                end
            end
        end
    end

    // State and match bookkeeping registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rv     <= 1'b0;
            round  <= 2'b00;
            game   <= 2'b00;
            played <= 6'd0;
            adv    <= 7'sd0;
            maxr   <= 6'd0;
            first  <= 1'b0;
            pwin   <= 2'b00;
            pmove  <= 2'b00;
            score1 <= '0;
            score2 <= '0;
        end else begin
            state  <= state_n;
            rv     <= rv_n;
            round  <= round_n;
            game   <= game_n;
            played <= played_n;
            adv    <= adv_n;
            maxr   <= maxr_n;
            first  <= first_n;
            pwin   <= pwin_n;
            pmove  <= pmove_n;
            score1 <= score1_n;
            score2 <= score2_n;
        end
    end

    assign ROUND_VALID = rv;
    assign ROUND       = round;
    assign GAME        = game;
    assign PLAYED      = played;
    assign BUSY        = (state == S_PLAY);
    assign SCORE1      = score1;
    assign SCORE2      = score2;

endmodule

// File: tb/tb_morra_cinese_match.sv
// Directed scoreboard bench for morra_cinese_match; a second instance runs with
// the repeat ban off and a 1-bit score to exercise those variants.
module tb_morra_cinese_match;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       START;
    logic       MOVE_VALID;
    logic [1:0] P1;
    logic [1:0] P2;

    logic       round_valid, nb_round_valid;
    logic [1:0] round, nb_round;
    logic [1:0] game, nb_game;
    logic [5:0] played, nb_played;
    logic       busy, nb_busy;
    logic [7:0] score1, score2;
    logic [0:0] nb_score1, nb_score2;

    logic [1:0] sb[$];
    int compared   = 0;
    int mismatched = 0;

    morra_cinese_match dut (
        .clk(clk), .rst_n(rst_n), .START(START), .MOVE_VALID(MOVE_VALID),
        .P1(P1), .P2(P2), .ROUND_VALID(round_valid), .ROUND(round),
        .GAME(game), .PLAYED(played), .BUSY(busy),
        .SCORE1(score1), .SCORE2(score2)
    );

    morra_cinese_match #(.REPEAT_BAN(0), .SCORE_W(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .START(START), .MOVE_VALID(MOVE_VALID),
        .P1(P1), .P2(P2), .ROUND_VALID(nb_round_valid), .ROUND(nb_round),
        .GAME(nb_game), .PLAYED(nb_played), .BUSY(nb_busy),
        .SCORE1(nb_score1), .SCORE2(nb_score2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] p1, input logic [1:0] p2,
                                 input logic exp_valid, input logic [1:0] exp_round);
        logic [1:0] want;
        @(negedge clk);
        P1 = p1;
        P2 = p2;
        MOVE_VALID = 1'b1;
        if (exp_valid) sb.push_back(exp_round);
        @(posedge clk);
        #1;
        checkOutput("round_valid", round_valid, exp_valid);
        if (round_valid) begin
            checkOutput("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                checkOutput("round", round, want);
            end
        end else begin
            checkOutput("round_idle", round, 2'b00);
        end
        @(negedge clk);
        MOVE_VALID = 1'b0;
    endtask

    task automatic startGame(input logic with_move);
        @(negedge clk);
        START = 1'b1;
        MOVE_VALID = with_move;
        P1 = 2'b01;
        P2 = 2'b11;
        @(posedge clk);
        #1;
        checkOutput("start_no_rv", round_valid, 1'b0);
        checkOutput("start_played", played, 6'd0);
        checkOutput("start_game", game, 2'b00);
        checkOutput("start_busy", busy, 1'b1);
        @(negedge clk);
        START = 1'b0;
        MOVE_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        START = 1'b0;
        MOVE_VALID = 1'b0;
        P1 = 2'b00;
        P2 = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rv", round_valid, 1'b0);
        checkOutput("rst_game", game, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_score1", score1, 8'd0);
        checkOutput("rst_played", played, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'b01, 2'b11, 1'b0, 2'b00);
        checkOutput("idle_busy", busy, 1'b0);

        startGame(1'b0);
        applyStimulus(2'b01, 2'b11, 1'b1, 2'b01);
        applyStimulus(2'b10, 2'b01, 1'b1, 2'b01);
        applyStimulus(2'b11, 2'b10, 1'b1, 2'b01);
        checkOutput("t1_mid_game", game, 2'b00);
        applyStimulus(2'b01, 2'b11, 1'b1, 2'b01);
        checkOutput("t1_game", game, 2'b01);
        checkOutput("t1_score1", score1, 8'd1);
        checkOutput("t1_score2", score2, 8'd0);
        checkOutput("t1_busy", busy, 1'b0);
        checkOutput("t1_played", played, 6'd4);
        checkOutput("t1_nb_score1", nb_score1, 1'b1);

        applyStimulus(2'b10, 2'b01, 1'b0, 2'b00);
        checkOutput("end_played", played, 6'd4);
        checkOutput("end_game", game, 2'b01);

        startGame(1'b0);
        applyStimulus(2'b01, 2'b11, 1'b1, 2'b01);
        applyStimulus(2'b01, 2'b10, 1'b1, 2'b00);
        checkOutput("t2_played", played, 6'd1);
        checkOutput("t2_nb_rv", nb_round_valid, 1'b1);
        checkOutput("t2_nb_round", nb_round, 2'b10);
        checkOutput("t2_nb_played", nb_played, 6'd2);
        applyStimulus(2'b10, 2'b10, 1'b1, 2'b11);
        checkOutput("t5_pre_played", played, 6'd2);

        startGame(1'b1);
        checkOutput("t5_score1", score1, 8'd1);
        checkOutput("t5_score2", score2, 8'd0);

        applyStimulus(2'b00, 2'b10, 1'b1, 2'b00);
        applyStimulus(2'b10, 2'b00, 1'b1, 2'b00);
        checkOutput("t3_played", played, 6'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b01, 2'b01, 1'b1, 2'b11);
            if (i == 4) begin
                checkOutput("t3_game_5", game, 2'b00);
                checkOutput("t3_busy_5", busy, 1'b1);
            end
        end
        checkOutput("t3_game", game, 2'b11);
        checkOutput("t3_played6", played, 6'd6);
        checkOutput("t3_busy", busy, 1'b0);
        checkOutput("t3_score1", score1, 8'd1);
        checkOutput("t3_score2", score2, 8'd0);
        checkOutput("t3_nb_game", nb_game, 2'b11);

        startGame(1'b0);
        for (int i = 0; i < 9; i++) begin
            logic [1:0] m;
            m = 2'(i % 3 + 1);
            applyStimulus(m, m, 1'b1, 2'b11);
            if (i == 7) checkOutput("t4_game_8", game, 2'b00);
        end
        checkOutput("t4_game", game, 2'b11);
        checkOutput("t4_played", played, 6'd9);
        checkOutput("t4_score1", score1, 8'd1);
        checkOutput("t4_score2", score2, 8'd0);

        startGame(1'b0);
        applyStimulus(2'b11, 2'b01, 1'b1, 2'b10);
        applyStimulus(2'b10, 2'b01, 1'b1, 2'b00);
        checkOutput("p2_void_played", played, 6'd1);
        applyStimulus(2'b01, 2'b10, 1'b1, 2'b10);
        applyStimulus(2'b10, 2'b11, 1'b1, 2'b10);
        applyStimulus(2'b11, 2'b01, 1'b1, 2'b10);
        checkOutput("p2_game", game, 2'b10);
        checkOutput("p2_score2", score2, 8'd1);
        checkOutput("p2_score1", score1, 8'd1);
        checkOutput("p2_busy", busy, 1'b0);

        startGame(1'b0);
        applyStimulus(2'b01, 2'b11, 1'b1, 2'b01);
        applyStimulus(2'b10, 2'b10, 1'b1, 2'b11);
        applyStimulus(2'b11, 2'b01, 1'b1, 2'b10);
        applyStimulus(2'b11, 2'b10, 1'b1, 2'b01);
        checkOutput("sat_game_4", game, 2'b00);
        checkOutput("sat_busy_4", busy, 1'b1);
        applyStimulus(2'b10, 2'b01, 1'b1, 2'b01);
        checkOutput("sat_game", game, 2'b01);
        checkOutput("sat_score1", score1, 8'd2);
        checkOutput("sat_nb_game", nb_game, 2'b01);
        checkOutput("sat_nb_score1", nb_score1, 1'b1);

        applyStimulus(2'b01, 2'b11, 1'b0, 2'b00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_score1", score1, 8'd0);
        checkOutput("t6_score2", score2, 8'd0);
        checkOutput("t6_game", game, 2'b00);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_played", played, 6'd0);

        checkOutput("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
